// File: rtl/poly_stream_host_if.sv
// poly_stream_host_if
//   Bundles the host-side FIFO ports and the evaluator-side x/y handshakes
//   of poly_stream_host.
//   slave  : view used by poly_stream_host (drives every o_* member).
//   master : view used by the surrounding logic (drives every i_* member).
//   Members: i_wr_en/i_wr_data/o_wr_full    host push into the sample FIFO
//            i_rd_en/o_rd_data/o_rd_empty   host pop from the result FIFO
//            i_flush                        discard queued samples
//            o_x/o_x_valid/i_x_ready        sample to the evaluator
//            i_y/i_y_valid/o_y_ready        result from the evaluator
interface poly_stream_host_if #(
  parameter int WIDTHIN  = 16,
  parameter int WIDTHOUT = 32
);
  logic                i_wr_en;
  logic [WIDTHIN-1:0]  i_wr_data;
  logic                o_wr_full;
  logic                i_rd_en;
  logic [WIDTHOUT-1:0] o_rd_data;
  logic                o_rd_empty;
  logic                i_flush;
  logic [WIDTHIN-1:0]  o_x;
  logic                o_x_valid;
  logic                i_x_ready;
  logic [WIDTHOUT-1:0] i_y;
  logic                i_y_valid;
  logic                o_y_ready;

  modport slave (
    input  i_wr_en, i_wr_data, i_rd_en, i_flush, i_x_ready, i_y, i_y_valid,
    output o_wr_full, o_rd_data, o_rd_empty, o_x, o_x_valid, o_y_ready
  );

  modport master (
    output i_wr_en, i_wr_data, i_rd_en, i_flush, i_x_ready, i_y, i_y_valid,
    input  o_wr_full, o_rd_data, o_rd_empty, o_x, o_x_valid, o_y_ready
  );
endinterface

// File: rtl/poly_stream_host.sv
// poly_stream_host
//   Feeds host x samples from a sample FIFO into the polynomial evaluator and
//   collects its Q7.25 y results in a first-word-fall-through result FIFO.
//   Issue is throttled by a credit so that in-flight plus buffered results
//   never exceed the result FIFO depth; results are therefore never dropped.
//   Ports:
//     clk, reset   sole clock, synchronous active-high reset
//     bus          poly_stream_host_if.slave (host FIFOs + evaluator handshakes)
//     o_busy       FSM not in IDLE
//     o_sent_cnt   samples issued (wraps)
//     o_recv_cnt   results accepted (wraps)
//     o_err        sticky protocol error
//   Configuration macro: POLY_HOST_PROTOCOL_CHECK_EN enables the o_err
//   protocol checks; when undefined o_err is tied low.
module poly_stream_host #(
  parameter int WIDTHIN  = 16,
  parameter int WIDTHOUT = 32,
  parameter int DEPTH    = 8,
  parameter int CNTW     = 16
) (
  input  logic                clk,
  input  logic                reset,
  poly_stream_host_if.slave   bus,
  output logic                o_busy,
  output logic [CNTW-1:0]     o_sent_cnt,
  output logic [CNTW-1:0]     o_recv_cnt,
  output logic                o_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, DRAIN = 2'd2} state_t;
  state_t state;

  logic [WIDTHIN-1:0]  sf_mem [DEPTH];
  logic [AW-1:0]       sf_wp, sf_rp;
  logic [CW-1:0]       sf_cnt;
  logic [WIDTHOUT-1:0] rf_mem [DEPTH];
  logic [AW-1:0]       rf_wp, rf_rp;
  logic [CW-1:0]       rf_cnt;
  logic [CW-1:0]       outstanding;
  logic                x_valid;
  logic [WIDTHIN-1:0]  x_data;
  logic [CNTW-1:0]     sent_cnt, recv_cnt;

  logic          sf_full, sf_empty, rf_full, rf_empty;
  logic          issue, accept, wr_ok, rd_ok, dec_ok;
  logic          head_avail, credit_ok, load;
  logic [AW-1:0] head_idx;
  logic [CW:0]   credit_use;

  // Handshake, FIFO status, credit and load decisions.
  always_comb begin
    sf_full  = (sf_cnt == DEPTH_C);
    sf_empty = (sf_cnt == {CW{1'b0}});
    rf_full  = (rf_cnt == DEPTH_C);
    rf_empty = (rf_cnt == {CW{1'b0}});
    issue    = x_valid && bus.i_x_ready;
    accept   = bus.i_y_valid && !rf_full;
    wr_ok    = bus.i_wr_en && !sf_full;
    rd_ok    = bus.i_rd_en && !rf_empty;
    // Unexpected results never push outstanding below zero.
    dec_ok   = accept && (outstanding != {CW{1'b0}});
    // The sample leaving this cycle is counted too: a freshly loaded o_x
    // cannot be withdrawn, so it must already own its credit.
    credit_use = {1'b0, outstanding} + {1'b0, rf_cnt} + {{CW{1'b0}}, issue};
    credit_ok  = (credit_use < {1'b0, DEPTH_C});
    // The head is popped only at issue, so on an issue cycle the next
    // sample sits one entry further along.
    if (issue) begin
      head_idx   = sf_rp + 1'b1;
      head_avail = (sf_cnt > CW'(1));
    end else begin
      head_idx   = sf_rp;
      head_avail = !sf_empty;
    end
    load = (state != DRAIN) && !bus.i_flush && (!x_valid || issue)
           && head_avail && credit_ok;
  end

  // Sample FIFO: pushes from the host, pops on issue, cleared by flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      sf_wp  <= {AW{1'b0}};
      sf_rp  <= {AW{1'b0}};
      sf_cnt <= {CW{1'b0}};
    end else if (bus.i_flush) begin
      sf_wp  <= {AW{1'b0}};
      sf_rp  <= {AW{1'b0}};
      sf_cnt <= {CW{1'b0}};
    end else begin
      if (wr_ok) begin
        sf_mem[sf_wp] <= bus.i_wr_data;
        sf_wp         <= sf_wp + 1'b1;
      end
      if (issue) begin
        sf_rp <= sf_rp + 1'b1;
      end
      sf_cnt <= sf_cnt + CW'(wr_ok) - CW'(issue);
    end
  end

  // Result FIFO: pushes on accept, pops on host read.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_wp  <= {AW{1'b0}};
      rf_rp  <= {AW{1'b0}};
      rf_cnt <= {CW{1'b0}};
    end else begin
      if (accept) begin
        rf_mem[rf_wp] <= bus.i_y;
        rf_wp         <= rf_wp + 1'b1;
      end
      if (rd_ok) begin
        rf_rp <= rf_rp + 1'b1;
      end
      rf_cnt <= rf_cnt + CW'(accept) - CW'(rd_ok);
    end
  end

  // Control FSM with the registered o_x / o_x_valid stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      x_valid <= 1'b0;
      x_data  <= {WIDTHIN{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (!sf_empty && !bus.i_flush) begin
            state <= STREAM;
          end
        end
        STREAM: begin
          if (bus.i_flush) begin
            state <= DRAIN;
          end else if (sf_empty && !x_valid && (outstanding == {CW{1'b0}})) begin
            state <= IDLE;
          end
        end
        DRAIN: begin
          if (outstanding == {CW{1'b0}}) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (load) begin
        x_valid <= 1'b1;
        x_data  <= sf_mem[head_idx];
      end else if (issue || (bus.i_flush && (state == STREAM))) begin
        x_valid <= 1'b0;
      end
    end
  end

  // In-flight tracking and wrapping sent/received counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding <= {CW{1'b0}};
      sent_cnt    <= {CNTW{1'b0}};
      recv_cnt    <= {CNTW{1'b0}};
    end else begin
      outstanding <= outstanding + CW'(issue) - CW'(dec_ok);
      sent_cnt    <= sent_cnt + CNTW'(issue);
      recv_cnt    <= recv_cnt + CNTW'(accept);
    end
  end

`ifdef POLY_HOST_PROTOCOL_CHECK_EN
  logic               err;
  logic               hold_prev;
  logic [WIDTHIN-1:0] x_prev;

  // Sticky protocol error: unexpected result, unstable held x, flush on issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      err       <= 1'b0;
      hold_prev <= 1'b0;
      x_prev    <= {WIDTHIN{1'b0}};
    end else begin
      hold_prev <= x_valid && !bus.i_x_ready;
      x_prev    <= x_data;
      if ((accept && (outstanding == {CW{1'b0}}))
          || (hold_prev && x_valid && (x_data != x_prev))
          || (bus.i_flush && issue)) begin
        err <= 1'b1;
      end
    end
  end

  assign o_err = err;
`else
  assign o_err = 1'b0;
`endif

  assign bus.o_x        = x_data;
  assign bus.o_x_valid  = x_valid;
  assign bus.o_wr_full  = sf_full;
  assign bus.o_rd_empty = rf_empty;
  assign bus.o_rd_data  = rf_empty ? {WIDTHOUT{1'b0}} : rf_mem[rf_rp];
  assign bus.o_y_ready  = !rf_full;
  assign o_busy         = (state != IDLE);
  assign o_sent_cnt     = sent_cnt;
  assign o_recv_cnt     = recv_cnt;
endmodule

// File: doc/poly_stream_host.md
# poly_stream_host

Stream-side counterpart to the polynomial evaluator. Host logic writes 16-bit x samples into an internal sample FIFO. This block drives them into the evaluator's input handshake, accepts the 32-bit Q7.25 y results from its output handshake, and buffers them in a result FIFO for the host to read. Credit tracking caps in-flight plus buffered results at the result FIFO depth, so no result is ever dropped.

## Interface
Parameters:
- WIDTHIN, 16: x sample width.
- WIDTHOUT, 32: y result width (Q7.25).
- DEPTH, 8: entries per FIFO; power of two, 2..64.
- CNTW, 16: width of the sent/received counters.

Ports:
- clk  in  1  sole clock; all logic on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clk.
- i_wr_en  in  1  host push into the sample FIFO.
- i_wr_data  in  WIDTHIN  sample to push.
- o_wr_full  out  1  sample FIFO full.
- i_rd_en  in  1  host pop from the result FIFO.
- o_rd_data  out  WIDTHOUT  head of the result FIFO (first-word-fall-through).
- o_rd_empty  out  1  result FIFO empty.
- i_flush  in  1  one-cycle pulse: discard queued samples, then drain in-flight results.
- o_x  out  WIDTHIN  sample to the evaluator.
- o_x_valid  out  1  o_x is valid.
- i_x_ready  in  1  evaluator accepts input.
- i_y  in  WIDTHOUT  result from the evaluator.
- i_y_valid  in  1  i_y is valid.
- o_y_ready  out  1  this block accepts a result.
- o_busy  out  1  state ≠ IDLE.
- o_sent_cnt  out  CNTW  samples issued, wraps modulo 2^CNTW.
- o_recv_cnt  out  CNTW  results accepted, wraps modulo 2^CNTW.
- o_err  out  1  sticky protocol error (see Configuration).

## Operation
- Issue fires on a cycle with o_x_valid && i_x_ready.
- Accept fires on a cycle with i_y_valid && o_y_ready.
- outstanding = issues − accepts, width log2(DEPTH)+1.
- credit_ok = (outstanding + result_count) < DEPTH.
- o_x_valid is registered. Once high, o_x_valid and o_x hold stable until an issue. It is never withdrawn, except by reset or flush.
- Each issue pops the sample FIFO.
- o_y_ready = !result_full, combinational from the registered count.
- FSM states:
  - IDLE: enter STREAM when the sample FIFO is not empty.
  - STREAM: load o_x when o_x_valid is low (or issue fires), sample FIFO is not empty, and credit_ok. Go to IDLE when the sample FIFO is empty, o_x_valid is low, and outstanding = 0. On i_flush, go to DRAIN.
  - DRAIN: sample FIFO cleared and o_x_valid dropped on entry; results keep being accepted. Go to IDLE when outstanding = 0.
- i_flush in IDLE or DRAIN: clears the sample FIFO only; state unchanged.
- Sample FIFO:
  - A write while full is ignored.
  - Write and issue on the same cycle when full: the write is still ignored; full is evaluated before the pop.
  - Write and issue on the same cycle when not full: count unchanged.
- Result FIFO:
  - Pop while empty is ignored.
  - Push and pop on the same cycle: count unchanged; data order preserved.
  - Pointers wrap modulo DEPTH.
- Counters wrap silently.

## Timing
- Reset values:
  - o_x_valid = 0, o_x = 0, o_wr_full = 0, o_rd_empty = 1, o_rd_data = 0.
  - o_y_ready = 1, o_busy = 0, o_sent_cnt = 0, o_recv_cnt = 0, o_err = 0.
  - Both FIFOs empty, outstanding = 0, state = IDLE.
- Write latency:
  - Write at edge N into an empty, idle block → o_x_valid = 1 after edge N+1 (one cycle for IDLE→STREAM plus the load).
  - Back-to-back issues sustain 1 sample/cycle while i_x_ready stays high and credit allows.
- Result latency: accept at edge N → o_rd_empty = 0 and o_rd_data valid after edge N.
- o_wr_full and o_rd_empty update on the edge of the push or pop.
- Reset mid-operation: all state cleared at that edge. In-flight results are forgotten; results arriving after reset count as unexpected.

## Configuration
- POLY_HOST_PROTOCOL_CHECK_EN defined: o_err sets (sticky until reset) on any of:
  - accept with outstanding = 0;
  - o_x changed while o_x_valid && !i_x_ready;
  - i_flush while o_x_valid && i_x_ready.

  The flush/issue collision still completes the issue first, then enters DRAIN.
- Not defined: o_err is tied to 0 and the check logic is absent. Functional behaviour is otherwise identical.

## Test plan
- Stream: push x = 0x0000, 0x4000, 0x8000; stub evaluator with i_x_ready = 1 returns y = x·0x100 after 5 cycles → result FIFO reads 0x00000000, 0x00400000, 0x00800000 in order; o_sent_cnt = o_recv_cnt = 3; back to IDLE.
- Backpressure: i_x_ready = 0 for 10 cycles with one sample queued → o_x_valid stays 1 and o_x stays constant; exactly one issue when ready rises.
- Credit: DEPTH = 8, host never reads, push 12 samples → exactly 8 issued; o_x_valid stays low after that; reading 1 result allows exactly 1 more issue.
- Full/empty: push 9 samples with i_x_ready = 0 → 9th write ignored; o_wr_full = 1 after the 8th. Pop while o_rd_empty → no change.
- Flush: 4 queued, 2 in flight, pulse i_flush → state DRAIN, sample FIFO empty; 2 results accepted; then IDLE with o_sent_cnt = 2.
- Check enabled: drive i_y_valid with outstanding = 0 → o_err = 1 next cycle and stays 1 until reset.
